branch_compare: RTL

//  Multi-cycle operand comparator. Produces the 3-bit {lt,eq,gt} flag vector consumed by the

---
 rtl/branch_compare_pkg.sv | 31 +++
 rtl/cmp_slice.sv | 16 +
 rtl/branch_compare.sv | 125 ++++++++++++
 3 files changed

// File: rtl/branch_compare_pkg.sv
// rtl/branch_compare_pkg.sv - shared flag indices, FSM states and branch decode codes
package branch_compare_pkg;

    localparam int FLAG_LT = 2;
    localparam int FLAG_EQ = 1;
    localparam int FLAG_GT = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMP  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0] ITYPE_BRANCH = 2'b10;
    localparam logic [1:0] ITYPE_JUMP   = 2'b11;

    localparam logic [1:0] BT_BEQ = 2'b00;
    localparam logic [1:0] BT_BNE = 2'b01;
    localparam logic [1:0] BT_BLT = 2'b10;
    localparam logic [1:0] BT_BGE = 2'b11;

    function automatic logic [2:0] make_flags(input logic lt, input logic gt);
        logic [2:0] f;
        f          = 3'b000;
        f[FLAG_LT] = lt;
        f[FLAG_GT] = gt;
        f[FLAG_EQ] = !lt && !gt;
        return f;
    endfunction

endpackage

// File: rtl/cmp_slice.sv
// rtl/cmp_slice.sv - combinational unsigned compare of one operand slice
module cmp_slice #(
    parameter int SLICE = 8
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    output logic             lt,
    output logic             eq,
    output logic             gt
);

    assign lt = (a < b);
    assign eq = (a == b);
    assign gt = (a > b);

endmodule

// File: rtl/branch_compare.sv
// rtl/branch_compare.sv - multi-cycle MSB-first sliced comparator producing {lt,eq,gt}
module branch_compare
    import branch_compare_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             is_signed,
    input  logic [1:0]       itype_in,
    input  logic [1:0]       branchtype_in,
    input  logic             flush,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [2:0]       flags,
    output logic [1:0]       itype_out,
    output logic [1:0]       branchtype_out
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NSLICE - 1);

    if (WIDTH % SLICE != 0) begin : g_bad_slice
        $error("branch_compare: WIDTH must be a multiple of SLICE");
    end

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_q, b_q;
    logic [IW-1:0]    idx;
    logic             decided, lt_q, gt_q;
    logic [SLICE-1:0] slice_a, slice_b;
    logic             s_lt, s_eq, s_gt;
    logic             accept, fin_lt, fin_gt;

    assign start_ready = (state == ST_IDLE) && !flush;
    assign accept      = start_valid && start_ready;
    assign res_valid   = (state == ST_DONE);

    assign slice_a = a_q[int'(idx)*SLICE +: SLICE];
    assign slice_b = b_q[int'(idx)*SLICE +: SLICE];

    cmp_slice #(.SLICE(SLICE)) u_cmp_slice (
        .a  (slice_a),
        .b  (slice_b),
        .lt (s_lt),
        .eq (s_eq),
        .gt (s_gt)
    );

    // A decision from a higher slice always outranks the current slice
    assign fin_lt = decided ? lt_q : s_lt;
    assign fin_gt = decided ? gt_q : s_gt;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept)         state_nxt = ST_CMP;
            ST_CMP:  if (idx == '0)      state_nxt = ST_DONE;
            ST_DONE: if (res_ready)      state_nxt = ST_IDLE;
            default:                     state_nxt = ST_IDLE;
        endcase
        if (flush) state_nxt = ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q            <= '0;
            b_q            <= '0;
            idx            <= '0;
            decided        <= 1'b0;
            lt_q           <= 1'b0;
            gt_q           <= 1'b0;
            flags          <= 3'b000;
            itype_out      <= 2'b00;
            branchtype_out <= 2'b00;
        end else if (flush) begin
            decided <= 1'b0;
            flags   <= 3'b000;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        // Biasing the sign bit turns a signed compare into an unsigned one
                        a_q            <= {op_a[WIDTH-1] ^ is_signed, op_a[WIDTH-2:0]};
                        b_q            <= {op_b[WIDTH-1] ^ is_signed, op_b[WIDTH-2:0]};
                        itype_out      <= itype_in;
                        branchtype_out <= branchtype_in;
                        idx            <= LAST_IDX;
                        decided        <= 1'b0;
                        lt_q           <= 1'b0;
                        gt_q           <= 1'b0;
                    end
                end
                ST_CMP: begin
                    if (!decided && !s_eq) begin
                        decided <= 1'b1;
                        lt_q    <= s_lt;
                        gt_q    <= s_gt;
                    end
                    if (idx == '0) begin
                        flags <= make_flags(fin_lt, fin_gt);
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
